// File: rtl/alu_pkg.sv
// Opcode constants and sequencer state encoding, shared by the sequencer and the ALU.
// Opcode values follow the instruction-set numbering: load=0 through not=18.
package alu_pkg;

    localparam int OPC_W = 5;
    localparam int REG_W = 4;

    localparam logic [OPC_W-1:0] OP_LOAD  = 5'd0;
    localparam logic [OPC_W-1:0] OP_LOADI = 5'd1;
    localparam logic [OPC_W-1:0] OP_STORE = 5'd2;
    localparam logic [OPC_W-1:0] OP_ADD   = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB   = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND   = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR    = 5'd6;
    localparam logic [OPC_W-1:0] OP_SHR   = 5'd7;
    localparam logic [OPC_W-1:0] OP_SHRA  = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHL   = 5'd9;
    localparam logic [OPC_W-1:0] OP_ROR   = 5'd10;
    localparam logic [OPC_W-1:0] OP_ROL   = 5'd11;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'd12;
    localparam logic [OPC_W-1:0] OP_ANDI  = 5'd13;
    localparam logic [OPC_W-1:0] OP_ORI   = 5'd14;
    localparam logic [OPC_W-1:0] OP_MUL   = 5'd15;
    localparam logic [OPC_W-1:0] OP_DIV   = 5'd16;
    localparam logic [OPC_W-1:0] OP_NEG   = 5'd17;
    localparam logic [OPC_W-1:0] OP_NOT   = 5'd18;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_LDY  = 3'd2,
        S_EXE  = 3'd3,
        S_WLO  = 3'd4,
        S_WHI  = 3'd5,
        S_FIN  = 3'd6
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of an instruction word into fields, legality and operand-class flags.
// Zero latency; no handshake of its own.
module instr_decoder
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 19
) (
    input  logic [31:0]       instr,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  ra,
    output logic [REG_W-1:0]  rb,
    output logic [REG_W-1:0]  rc,
    output logic [DATA_W-1:0] imm_ext,
    output logic              legal,
    output logic              is_wide,
    output logic              is_imm,
    output logic              is_unary
);

    assign opcode  = instr[31:27];
    assign ra      = instr[26:23];
    assign rb      = instr[22:19];
    assign rc      = instr[18:15];
    assign imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

    always_comb begin
        legal    = 1'b0;
        is_wide  = 1'b0;
        is_imm   = 1'b0;
        is_unary = 1'b0;
        case (opcode)
            // memory ops are handled elsewhere and rejected here
            OP_LOAD, OP_LOADI, OP_STORE: legal = 1'b0;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: legal = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: begin
                legal  = 1'b1;
                is_imm = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                legal   = 1'b1;
                is_wide = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                legal    = 1'b1;
                is_unary = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer driving register file, ALU and Z/LO/HI for one instruction.
// Done 5 cycles after accept (6 for mul/div, 2 for illegal); instr_ready only in IDLE.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 19
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [REG_W-1:0]  rf_raddr,
    output logic              y_load,
    output logic              b_sel_imm,
    output logic [DATA_W-1:0] imm_out,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              z_load,
    output logic              z_lo_out,
    output logic              z_hi_out,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic              lo_we,
    output logic              hi_we,
    output logic              inc_pc,
    output logic              done,
    output logic              illegal
);

    state_t             state, state_nxt;
    logic [31:0]        instr_q;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   ra, rb, rc;
    logic [DATA_W-1:0]  imm_ext;
    logic               legal, is_wide, is_imm, is_unary;

    instr_decoder #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_dec (
        .instr    (instr_q),
        .opcode   (opcode),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .imm_ext  (imm_ext),
        .legal    (legal),
        .is_wide  (is_wide),
        .is_imm   (is_imm),
        .is_unary (is_unary)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr_q <= '0;
        end else if (instr_valid && instr_ready) begin
            instr_q <= instr;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (instr_valid) state_nxt = S_DEC;
            S_DEC:   state_nxt = legal ? S_LDY : S_FIN;
            S_LDY:   state_nxt = S_EXE;
            S_EXE:   state_nxt = S_WLO;
            S_WLO:   state_nxt = is_wide ? S_WHI : S_FIN;
            S_WHI:   state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Cleared latch makes imm_out read zero after reset until the first accept.
    assign imm_out = imm_ext;

    always_comb begin
        instr_ready = 1'b0;
        rf_raddr    = '0;
        y_load      = 1'b0;
        b_sel_imm   = 1'b0;
        alu_opcode  = '0;
        z_load      = 1'b0;
        z_lo_out    = 1'b0;
        z_hi_out    = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        lo_we       = 1'b0;
        hi_we       = 1'b0;
        inc_pc      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: instr_ready = 1'b1;
            S_LDY: begin
                rf_raddr   = rb;
                y_load     = 1'b1;
                alu_opcode = opcode;
            end
            S_EXE: begin
                alu_opcode = opcode;
                z_load     = 1'b1;
                if (is_imm) begin
                    b_sel_imm = 1'b1;
                end else if (is_unary) begin
                    rf_raddr = rb;
                end else begin
                    rf_raddr = rc;
                end
            end
            S_WLO: begin
                alu_opcode = opcode;
                z_lo_out   = 1'b1;
                if (is_wide) begin
                    lo_we = 1'b1;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = ra;
                end
            end
            S_WHI: begin
                alu_opcode = opcode;
                z_hi_out   = 1'b1;
                hi_we      = 1'b1;
            end
            S_FIN: begin
                done    = 1'b1;
                inc_pc  = 1'b1;
                illegal = ~legal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues expected strobe cycles, a negedge monitor checks them.
module tb_alu_sequencer;

    localparam int K_REG = 0;
    localparam int K_IMM = 1;
    localparam int K_UN  = 2;
    localparam int K_WIDE = 3;
    localparam int K_ILL = 4;

    typedef struct packed {
        logic [3:0]  raddr;
        logic        y_load;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        z_load;
        logic        z_lo;
        logic        z_hi;
        logic        rf_we;
        logic [3:0]  waddr;
        logic        lo_we;
        logic        hi_we;
        logic        inc_pc;
        logic        done;
        logic        illegal;
        logic        rdy;
    } out_t;

    typedef struct {
        string name;
        int    off;
        out_t  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  rf_raddr, rf_waddr;
    logic        y_load, b_sel_imm, z_load, z_lo_out, z_hi_out, rf_we;
    logic        lo_we, hi_we, inc_pc, done, illegal;
    logic [31:0] imm_out;
    logic [4:0]  alu_opcode;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    int   acc_q[$];

    alu_sequencer #(.DATA_W(32), .IMM_W(19)) dut (
        .clk         (clk),
        .clr         (clr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr    (rf_raddr),
        .y_load      (y_load),
        .b_sel_imm   (b_sel_imm),
        .imm_out     (imm_out),
        .alu_opcode  (alu_opcode),
        .z_load      (z_load),
        .z_lo_out    (z_lo_out),
        .z_hi_out    (z_hi_out),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .lo_we       (lo_we),
        .hi_we       (hi_we),
        .inc_pc      (inc_pc),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic out_t snap();
        out_t o;
        o.raddr   = rf_raddr;
        o.y_load  = y_load;
        o.b_sel   = b_sel_imm;
        o.imm     = imm_out;
        o.alu_op  = alu_opcode;
        o.z_load  = z_load;
        o.z_lo    = z_lo_out;
        o.z_hi    = z_hi_out;
        o.rf_we   = rf_we;
        o.waddr   = rf_waddr;
        o.lo_we   = lo_we;
        o.hi_we   = hi_we;
        o.inc_pc  = inc_pc;
        o.done    = done;
        o.illegal = illegal;
        o.rdy     = instr_ready;
        return o;
    endfunction

    // Monitor: every cycle with any strobe high must match the next queued expectation.
    always @(negedge clk) begin
        out_t cur;
        exp_t e;
        cyc++;
        cur = snap();
        if (cur.y_load | cur.z_load | cur.z_lo | cur.z_hi | cur.rf_we | cur.lo_we |
            cur.hi_we | cur.inc_pc | cur.done | cur.illegal) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got=%h at offset %0d, required no strobe", cur, cyc - acc_cyc);
            end else begin
                e = sb.pop_front();
                if (cur !== e.v || (cyc - acc_cyc) != e.off) begin
                    bad++;
                    $display("FAIL %s: got=%h off=%0d required=%h off=%0d", e.name, cur, cyc - acc_cyc, e.v, e.off);
                end
            end
            if (cur.done) done_cnt++;
        end
        if (clr && instr_valid && instr_ready) begin
            acc_cyc = cyc;
            acc_q.push_back(cyc);
        end
    end

    task automatic push_exp(input string nm, input logic [4:0] op, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [3:0] rc,
                            input logic [31:0] eimm, input int kind);
        exp_t e;
        if (kind == K_ILL) begin
            e.name = {nm, "_fin"}; e.off = 2; e.v = '0;
            e.v.imm = eimm; e.v.done = 1'b1; e.v.inc_pc = 1'b1; e.v.illegal = 1'b1;
            sb.push_back(e);
            return;
        end
        e.name = {nm, "_ldy"}; e.off = 2; e.v = '0;
        e.v.imm = eimm; e.v.raddr = rb; e.v.y_load = 1'b1; e.v.alu_op = op;
        sb.push_back(e);
        e.name = {nm, "_exe"}; e.off = 3; e.v = '0;
        e.v.imm = eimm; e.v.z_load = 1'b1; e.v.alu_op = op;
        if (kind == K_IMM)     e.v.b_sel = 1'b1;
        else if (kind == K_UN) e.v.raddr = rb;
        else                   e.v.raddr = rc;
        sb.push_back(e);
        e.name = {nm, "_wlo"}; e.off = 4; e.v = '0;
        e.v.imm = eimm; e.v.z_lo = 1'b1; e.v.alu_op = op;
        if (kind == K_WIDE) e.v.lo_we = 1'b1;
        else begin e.v.rf_we = 1'b1; e.v.waddr = ra; end
        sb.push_back(e);
        if (kind == K_WIDE) begin
            e.name = {nm, "_whi"}; e.off = 5; e.v = '0;
            e.v.imm = eimm; e.v.z_hi = 1'b1; e.v.hi_we = 1'b1; e.v.alu_op = op;
            sb.push_back(e);
        end
        e.name = {nm, "_fin"}; e.off = (kind == K_WIDE) ? 6 : 5; e.v = '0;
        e.v.imm = eimm; e.v.done = 1'b1; e.v.inc_pc = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm, input int target);
        for (int i = 0; i < 40 && done_cnt < target; i++) @(posedge clk);
        #1;
        total++;
        if (done_cnt != target) begin
            bad++;
            $display("FAIL %s_done_count: got=%0d required=%0d", nm, done_cnt, target);
        end
    endtask

    task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc,
                       input logic [31:0] eimm, input int kind);
        logic [4:0] op;
        int tgt;
        op  = ins[31:27];
        tgt = done_cnt + 1;
        push_exp(nm, op, ra, rb, rc, eimm, kind);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'hDEAD_BEEF;
        wait_done(nm, tgt);
    endtask

    task automatic check_idle(input string nm);
        out_t exp_o;
        out_t got;
        exp_o = '0;
        exp_o.rdy = 1'b1;
        got = snap();
        total++;
        if (got !== exp_o) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", nm, got, exp_o);
        end
    endtask

    initial begin
        int n0;
        int tgt;
        #2;
        check_idle("reset_outputs");
        @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run("add_r1_r2_r3", 32'h1891_8000, 4'd1, 4'd2, 4'd3, 32'h0001_8000, K_REG);
        run("mul", {5'd15, 4'd4, 4'd5, 4'd6, 15'd0}, 4'd4, 4'd5, 4'd6, 32'h0003_0000, K_WIDE);
        run("addi_neg", {5'd12, 4'd7, 4'd8, 19'h7FFFF}, 4'd7, 4'd8, 4'd0, 32'hFFFF_FFFF, K_IMM);
        run("ori_pos", {5'd14, 4'd3, 4'd9, 19'h3FFFF}, 4'd3, 4'd9, 4'd0, 32'h0003_FFFF, K_IMM);
        run("illegal_1f", 32'hF800_0000, 4'd0, 4'd0, 4'd0, 32'h0000_0000, K_ILL);
        run("illegal_01", {5'd1, 4'd1, 4'd2, 19'h0}, 4'd1, 4'd2, 4'd0, 32'h0000_0000, K_ILL);
        run("neg", {5'd17, 4'd9, 4'd10, 4'd0, 15'd0}, 4'd9, 4'd10, 4'd0, 32'h0000_0000, K_UN);
        run("sub", {5'd4, 4'd15, 4'd0, 4'd14, 15'd0}, 4'd15, 4'd0, 4'd14, 32'hFFFF_0000, K_REG);

        // div aborted by reset in EXE: only its LDY strobe may appear
        push_exp("div_abort", 5'd16, 4'd2, 4'd3, 4'd4, 32'h0002_0000, K_WIDE);
        n0 = done_cnt;
        instr = {5'd16, 4'd2, 4'd3, 4'd4, 15'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_idle("reset_in_exe");
        total++;
        if (sb.size() != 4) begin
            bad++;
            $display("FAIL div_abort_progress: got=%0d pending required=4", sb.size());
        end
        sb.delete();
        @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (done_cnt != n0) begin
            bad++;
            $display("FAIL div_abort_no_done: got=%0d required=%0d", done_cnt, n0);
        end
        check_idle("idle_after_abort");

        // three adds with instr_valid held high
        n0 = acc_q.size();
        tgt = done_cnt + 3;
        for (int k = 0; k < 3; k++)
            push_exp("b2b_add", 5'd3, 4'd1, 4'd2, 4'd3, 32'h0001_8000, K_REG);
        instr = 32'h1891_8000;
        instr_valid = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wait_done("b2b", tgt);
        total++;
        if (acc_q.size() != n0 + 3) begin
            bad++;
            $display("FAIL b2b_accept_count: got=%0d required=3", acc_q.size() - n0);
        end else begin
            for (int k = 1; k < 3; k++) begin
                total++;
                if (acc_q[n0 + k] - acc_q[n0 + k - 1] != 6) begin
                    bad++;
                    $display("FAIL b2b_spacing: got=%0d required=6", acc_q[n0 + k] - acc_q[n0 + k - 1]);
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
